// File: rtl/bvashr_chk_pkg.sv
// Shared types and helpers for the bvashr witness checker.
// Optional mismatch counter build switch: BVASHR_CHK_MISMATCH_CNT_EN.
package bvashr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MISMATCH_CW = 16;

    // Shifting more than w places cannot change an arithmetic result further.
    function automatic int unsigned shamt_cap(
        input logic [31:0] s,
        input int unsigned w
    );
        return (s >= 32'(w)) ? w : int'(s);
    endfunction

endpackage

// File: rtl/bvashr_serial_shifter.sv
// Serial arithmetic right shifter: one bit position per step.
// Holds the working result and the remaining shift count.
module bvashr_serial_shifter
    import bvashr_chk_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [W-1:0]  x,
    input  logic [CW-1:0] n,
    output logic [W-1:0]  res,
    output logic          last
);

    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        res_d = res_q;
        cnt_d = cnt_q;
        if (load) begin
            res_d = x;
            cnt_d = n;
        end else if (step && (cnt_q != '0)) begin
            res_d = {res_q[W-1], res_q[W-1:1]};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign res  = res_q;
    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/bvashr_witness_checker.sv
// Confirms x >>a s == t by shifting serially, then reporting res and match.
// Define BVASHR_CHK_MISMATCH_CNT_EN to add a saturating mismatch_cnt output.
module bvashr_witness_checker
    import bvashr_chk_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef BVASHR_CHK_MISMATCH_CNT_EN
    output logic [MISMATCH_CW-1:0] mismatch_cnt,
`endif
    output logic [W-1:0] res,
    output logic         match
);

    localparam int CW = $clog2(W + 1);

    state_e        state_q, state_d;
    logic [W-1:0]  t_q, t_d;
    logic [CW-1:0] n;
    logic          load;
    logic          step;
    logic          last;
    logic [W-1:0]  sh_res;

    assign n = CW'(shamt_cap(32'(s), W));

    bvashr_serial_shifter #(
        .W  (W),
        .CW (CW)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .x    (x),
        .n    (n),
        .res  (sh_res),
        .last (last)
    );

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    t_d     = t;
                    state_d = (n != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    assign res = sh_res;
    // Gated by DONE so the reset state (res=0, t_q=0) does not read as a match.
    assign match = out_valid && (sh_res == t_q);

`ifdef BVASHR_CHK_MISMATCH_CNT_EN
    logic [MISMATCH_CW-1:0] mm_q, mm_d;

    always_comb begin
        mm_d = mm_q;
        if (out_valid && out_ready && !match && (mm_q != '1))
            mm_d = mm_q + MISMATCH_CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) mm_q <= '0;
        else     mm_q <= mm_d;
    end

    assign mismatch_cnt = mm_q;
`endif

endmodule
